mips_control_alu: RTL and testbench



---
 rtl/mips_control_alu.sv | 160 ++++++++++++++++
 tb/tb_mips_control_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mips_control_alu.sv
// mips_control_alu
// Combinational decode/execute core of a single-cycle MIPS datapath:
//   * main control: opcode -> datapath selects and enables
//   * ALU control:  alu_op + funct -> 4-bit ALU operation
//   * 32-bit ALU:   result + zero flag
// The only state is the sticky halted flag, set by the halt opcode (0x3F)
// and cleared only by reset.
//
// Ports
//   clk        in   1   clock; halted updates on the rising edge
//   reset      in   1   synchronous, active-high; clears halted
//   opcode     in   6   instruction[31:26]
//   funct      in   6   instruction[5:0]
//   src_a      in  32   ALU operand A
//   src_b      in  32   ALU operand B (already muxed with the immediate)
//   reg_dst    out  1   1 = write register is rd
//   jump       out  1   next PC from the jump target
//   branch     out  1   branch instruction (taken when branch & zero)
//   mem_read   out  1   data-memory read enable
//   mem_to_reg out  1   write-back from memory
//   mem_write  out  1   data-memory write enable
//   alu_src    out  1   B operand is the immediate
//   reg_write  out  1   register-file write enable
//   alu_op     out  2   ALU op class
//   operation  out  4   decoded ALU operation
//   result     out 32   ALU result
//   zero       out  1   result == 0
//   halted     out  1   registered sticky halt flag
module mips_control_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        reg_dst,
  output logic        jump,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic [3:0]  operation,
  output logic [31:0] result,
  output logic        zero,
  output logic        halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Main control. Halt and unknown opcodes fall to the all-zero default.
  always_comb begin
    reg_dst    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control. Unrecognised funct codes and alu_op=11 decode to add.
  always_comb begin
    operation = ALU_ADD;
    case (alu_op)
      2'b01: operation = ALU_SUB;
      2'b10: begin
        case (funct)
          6'h20:   operation = ALU_ADD;
          6'h22:   operation = ALU_SUB;
          6'h24:   operation = ALU_AND;
          6'h25:   operation = ALU_OR;
          6'h2A:   operation = ALU_SLT;
          6'h27:   operation = ALU_NOR;
          default: operation = ALU_ADD;
        endcase
      end
      default: operation = ALU_ADD;
    endcase
  end

  // ALU. Add/sub wrap modulo 2^32; slt compares as signed two's complement.
  always_comb begin
    result = 32'd0;
    case (operation)
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_SLT: result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      ALU_NOR: result = ~(src_a | src_b);
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

  // Sticky halt flag; reset takes priority over a halt opcode on the same edge.
  logic halted_q;
  logic halted_d;

  always_comb begin
    halted_d = halted_q;
    if (opcode == OP_HALT) halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halted = halted_q;

endmodule

// File: tb/tb_mips_control_alu.sv
// Testbench for mips_control_alu: directed steps, one per clock cycle.
// Each step drives inputs on the falling edge, pushes the expected output
// word to exp_q, and pops/compares it shortly afterwards.
// Expected word layout (48 bits):
//   [47] halted  [46:37] controls {reg_dst,jump,branch,mem_read,mem_to_reg,
//   mem_write,alu_src,reg_write,alu_op[1:0]}  [36:33] operation  [32] zero
//   [31:0] result
module tb_mips_control_alu;

  localparam int W = 48;

  localparam logic [9:0] CTL_R    = 10'b1000000110;
  localparam logic [9:0] CTL_LW   = 10'b0001101100;
  localparam logic [9:0] CTL_SW   = 10'b0000011000;
  localparam logic [9:0] CTL_BEQ  = 10'b0010000001;
  localparam logic [9:0] CTL_ADDI = 10'b0000001100;
  localparam logic [9:0] CTL_J    = 10'b0100000000;
  localparam logic [9:0] CTL_NONE = 10'b0000000000;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        reg_dst;
  logic        jump;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [1:0]  alu_op;
  logic [3:0]  operation;
  logic [31:0] result;
  logic        zero;
  logic        halted;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  mips_control_alu dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .src_a      (src_a),
    .src_b      (src_b),
    .reg_dst    (reg_dst),
    .jump       (jump),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .operation  (operation),
    .result     (result),
    .zero       (zero),
    .halted     (halted)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver: drive one step and queue its expected output
  task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic hlt, input logic [9:0] ctl,
                       input logic [3:0] oper, input logic [31:0] res);
    @(negedge clk);
    reset  = rst;
    opcode = op;
    funct  = fn;
    src_a  = a;
    src_b  = b;
    exp_q.push_back({hlt, ctl, oper, (res == 32'd0), res});
  endtask

  // Scoreboard: pop expected word, compare with the DUT output
  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    #2;
    obs = {halted, reg_dst, jump, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_op, operation, zero, result};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s obs=%h exp=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic hlt, input logic [9:0] ctl,
                      input logic [3:0] oper, input logic [31:0] res);
    drive(rst, op, fn, a, b, hlt, ctl, oper, res);
    check(tag);
  endtask

  // Stimulus
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h20;
    src_a  = 32'h0;
    src_b  = 32'h0;

    // Reset held for two edges; combinational path unaffected by reset
    step("rst_1", 1'b1, 6'h00, 6'h20, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0010, 32'h16);
    step("rst_2", 1'b1, 6'h00, 6'h20, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0010, 32'h16);

    // R-type sweep
    step("r_add", 1'b0, 6'h00, 6'h20, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0010, 32'h16);
    step("r_sub", 1'b0, 6'h00, 6'h22, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0110, 32'h02);
    step("r_and", 1'b0, 6'h00, 6'h24, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0000, 32'h08);
    step("r_or",  1'b0, 6'h00, 6'h25, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0001, 32'h0E);
    step("r_nor", 1'b0, 6'h00, 6'h27, 32'hC, 32'hA, 1'b0, CTL_R, 4'b1100, 32'hFFFFFFF1);
    step("r_slt", 1'b0, 6'h00, 6'h2A, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0111, 32'h0);
    step("r_unk_funct", 1'b0, 6'h00, 6'h3F, 32'hC, 32'hA, 1'b0, CTL_R, 4'b0010, 32'h16);

    // Memory ops
    step("lw", 1'b0, 6'h23, 6'h00, 32'h1000, 32'h4, 1'b0, CTL_LW, 4'b0010, 32'h1004);
    step("sw", 1'b0, 6'h2B, 6'h00, 32'h1000, 32'h4, 1'b0, CTL_SW, 4'b0010, 32'h1004);

    // Branch / jump
    step("beq_eq", 1'b0, 6'h04, 6'h00, 32'h55, 32'h55, 1'b0, CTL_BEQ, 4'b0110, 32'h0);
    step("beq_ne", 1'b0, 6'h04, 6'h00, 32'h55, 32'h54, 1'b0, CTL_BEQ, 4'b0110, 32'h1);
    step("j", 1'b0, 6'h02, 6'h2A, 32'h3, 32'h4, 1'b0, CTL_J, 4'b0010, 32'h7);

    // Arithmetic boundaries
    step("addi_wrap", 1'b0, 6'h08, 6'h00, 32'hFFFFFFFF, 32'h1, 1'b0, CTL_ADDI, 4'b0010, 32'h0);
    step("sub_wrap", 1'b0, 6'h00, 6'h22, 32'h0, 32'h1, 1'b0, CTL_R, 4'b0110, 32'hFFFFFFFF);
    step("slt_neg_1", 1'b0, 6'h00, 6'h2A, 32'h80000000, 32'h1, 1'b0, CTL_R, 4'b0111, 32'h1);
    step("slt_min_max", 1'b0, 6'h00, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 1'b0, CTL_R, 4'b0111, 32'h1);
    step("slt_max_min", 1'b0, 6'h00, 6'h2A, 32'h7FFFFFFF, 32'h80000000, 1'b0, CTL_R, 4'b0111, 32'h0);
    step("slt_equal", 1'b0, 6'h00, 6'h2A, 32'h1234, 32'h1234, 1'b0, CTL_R, 4'b0111, 32'h0);
    step("unk_opcode", 1'b0, 6'h15, 6'h22, 32'h5, 32'h3, 1'b0, CTL_NONE, 4'b0010, 32'h8);

    // Random adds and subtracts
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      step("rand_add", 1'b0, 6'h00, 6'h20, ra, rb, 1'b0, CTL_R, 4'b0010, ra + rb);
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      step("rand_sub", 1'b0, 6'h04, 6'h00, ra, rb, 1'b0, CTL_BEQ, 4'b0110, ra - rb);
    end

    // Halt flag: halted reflects the previous edge at each sample point
    step("halt_issue", 1'b0, 6'h3F, 6'h00, 32'h1, 32'h2, 1'b0, CTL_NONE, 4'b0010, 32'h3);
    step("halt_set", 1'b0, 6'h00, 6'h20, 32'h1, 32'h2, 1'b1, CTL_R, 4'b0010, 32'h3);
    step("halt_sticky", 1'b0, 6'h00, 6'h20, 32'h1, 32'h2, 1'b1, CTL_R, 4'b0010, 32'h3);
    step("halt_rst_race", 1'b1, 6'h3F, 6'h00, 32'h1, 32'h2, 1'b1, CTL_NONE, 4'b0010, 32'h3);
    step("halt_reissue", 1'b0, 6'h3F, 6'h00, 32'h1, 32'h2, 1'b0, CTL_NONE, 4'b0010, 32'h3);
    step("halt_unk_op", 1'b0, 6'h15, 6'h00, 32'h1, 32'h2, 1'b1, CTL_NONE, 4'b0010, 32'h3);
    step("halt_rst", 1'b1, 6'h00, 6'h20, 32'h1, 32'h2, 1'b1, CTL_R, 4'b0010, 32'h3);
    step("halt_cleared", 1'b0, 6'h15, 6'h00, 32'h1, 32'h2, 1'b0, CTL_NONE, 4'b0010, 32'h3);
    step("halt_stays_0", 1'b0, 6'h00, 6'h20, 32'h1, 32'h2, 1'b0, CTL_R, 4'b0010, 32'h3);

    // Final report
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
